// File: rtl/zeroheti_pkg.sv
// Shared definitions for the zeroheti OBI arbiter slice: default sizes and
// the manager-index type used for routing responses.
package zeroheti_pkg;

    localparam int unsigned ArbDefaultNumMgr   = 3;
    localparam int unsigned ArbDefaultMaxTrans = 2;

    // Index width for n managers; never narrower than one bit.
    function automatic int unsigned arb_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ArbIdxWidth = arb_idx_width(ArbDefaultNumMgr);

    typedef logic [ArbIdxWidth-1:0] arb_idx_t;

endpackage

// File: rtl/zeroheti_arb_id_fifo.sv
// Small FIFO that remembers which manager owns each outstanding transaction.
// The head entry is read combinationally so responses route in the same cycle.
module zeroheti_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Overflowing pushes and underflowing pops are ignored.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap at Depth so non-power-of-two depths work.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/zeroheti_obi_arbiter.sv
// Round-robin N-to-1 OBI arbiter. A stalled request is held on its manager
// until granted; responses are routed back in order through an ID FIFO.
// Optional per-manager stall counters: define ZEROHETI_ARB_STALL_CNT_EN.
module zeroheti_obi_arbiter
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumMgr    = ArbDefaultNumMgr,
    parameter int unsigned MaxTrans  = ArbDefaultMaxTrans,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumMgr-1:0]                     sbr_req_i,
    input  logic [NumMgr-1:0][AddrWidth-1:0]      sbr_addr_i,
    input  logic [NumMgr-1:0]                     sbr_we_i,
    input  logic [NumMgr-1:0][DataWidth/8-1:0]    sbr_be_i,
    input  logic [NumMgr-1:0][DataWidth-1:0]      sbr_wdata_i,
    output logic [NumMgr-1:0]                     sbr_gnt_o,
    output logic [NumMgr-1:0]                     sbr_rvalid_o,
    output logic [DataWidth-1:0]                  sbr_rdata_o,
    output logic                                  sbr_err_o,
    output logic                                  mgr_req_o,
    input  logic                                  mgr_gnt_i,
    output logic [AddrWidth-1:0]                  mgr_addr_o,
    output logic                                  mgr_we_o,
    output logic [DataWidth/8-1:0]                mgr_be_o,
    output logic [DataWidth-1:0]                  mgr_wdata_o,
    input  logic                                  mgr_rvalid_i,
    input  logic [DataWidth-1:0]                  mgr_rdata_i,
    input  logic                                  mgr_err_i
`ifdef ZEROHETI_ARB_STALL_CNT_EN
    ,
    output logic [NumMgr-1:0][CntWidth-1:0]       stall_cnt_o
`endif
);

    localparam int unsigned IdxW     = arb_idx_width(NumMgr);
    localparam int unsigned FifoCntW = $clog2(MaxTrans + 1);

    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     hold_idx_q, hold_idx_d;
    logic                hold_q, hold_d;
    logic [IdxW-1:0]     rr_winner, winner;
    logic                rr_found;
    logic                handshake;
    logic                fifo_full, fifo_empty;
    logic [IdxW-1:0]     fifo_head;
    logic [FifoCntW-1:0] fifo_count;

    // First requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        rr_winner = rr_ptr_q;
        rr_found  = 1'b0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            int unsigned cand;
            cand = int'(rr_ptr_q) + i;
            if (cand >= NumMgr) begin
                cand = cand - NumMgr;
            end
            if (!rr_found && sbr_req_i[IdxW'(cand)]) begin
                rr_winner = IdxW'(cand);
                rr_found  = 1'b1;
            end
        end
    end

    // A presented but ungranted request must stay on the same manager.
    assign winner    = hold_q ? hold_idx_q : rr_winner;
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign mgr_req_o = (|sbr_req_i) & ~fifo_full;
    assign handshake = mgr_req_o & mgr_gnt_i;

    // Request mux, grant steering and response routing.
    always_comb begin
        mgr_addr_o   = '0;
        mgr_we_o     = 1'b0;
        mgr_be_o     = '0;
        mgr_wdata_o  = '0;
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        if (mgr_req_o) begin
            mgr_addr_o        = sbr_addr_i[winner];
            mgr_we_o          = sbr_we_i[winner];
            mgr_be_o          = sbr_be_i[winner];
            mgr_wdata_o       = sbr_wdata_i[winner];
            sbr_gnt_o[winner] = mgr_gnt_i;
        end
        if (mgr_rvalid_i && !fifo_empty) begin
            sbr_rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign sbr_rdata_o = mgr_rdata_i;
    assign sbr_err_o   = mgr_err_i;

    // Next-state for round-robin pointer and hold tracking.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        hold_d     = hold_q;
        hold_idx_d = hold_idx_q;
        if (handshake) begin
            rr_ptr_d = (winner == IdxW'(NumMgr - 1)) ? '0 : winner + IdxW'(1);
            hold_d   = 1'b0;
        end else if (mgr_req_o) begin
            hold_d     = 1'b1;
            hold_idx_d = winner;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    zeroheti_arb_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW),
        .CntW  (FifoCntW)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (winner),
        .pop_i   (mgr_rvalid_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

`ifdef ZEROHETI_ARB_STALL_CNT_EN
    // Per-manager saturating count of cycles spent requesting without a grant.
    for (genvar gi = 0; gi < NumMgr; gi++) begin : g_stall_cnt
        logic [CntWidth-1:0] cnt_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (sbr_req_i[gi] && !sbr_gnt_o[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
        assign stall_cnt_o[gi] = cnt_q;
    end
`else
    logic [CntWidth-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

    logic [FifoCntW-1:0] unused_fifo_count;
    assign unused_fifo_count = fifo_count;

`ifndef SYNTHESIS
    // A response with nothing outstanding is a subordinate protocol error.
    rvalid_needs_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni) mgr_rvalid_i |-> !fifo_empty
    );
`endif

endmodule
